// File: rtl/fifo_2048x8.sv
// Single-clock 2048x8 FIFO with full/empty, almost-full/almost-empty flags and an occupancy count.
// Read latency 1 cycle (2 cycles with FIFO_OUTPUT_REG_EN defined); flags/level update 1 cycle after the accepting edge.
// Backpressure: writes while full are dropped and reads while empty are ignored; rd_data holds between accepted reads.
module fifo_2048x8 #(
    parameter int unsigned DEPTH_WIDTH      = 11,
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned ALMOST_FULL_NUM  = 1020,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic [DEPTH_WIDTH:0]  rd_water_level,
    output logic                  almost_empty
);

    // Pointers carry one extra wrap bit so that full and empty are distinguishable.
    localparam int unsigned PW    = DEPTH_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;

    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
    localparam logic [PW-1:0] AF_LVL   = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_LVL   = PW'(ALMOST_EMPTY_NUM);
    localparam logic [PW-1:0] ONE      = PW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         level_q,  level_d;
    logic                  full_q,   full_d;
    logic                  empty_q,  empty_d;
    logic                  afull_q,  afull_d;
    logic                  aempty_q, aempty_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  wr_accept;
    logic                  rd_accept;

    // Acceptance uses the registered flags, i.e. the state before the edge.
    assign wr_accept = wr_en && !full_q;
    assign rd_accept = rd_en && !empty_q;

    // Next pointers, next level and next flags; flags are computed from the
    // next level so the registered flags always match the registered level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + ONE;
        if (rd_accept) rd_ptr_d = rd_ptr_q + ONE;
        level_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (level_d == FULL_LVL);
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= AF_LVL);
        aempty_d = (level_d <= AE_LVL);
    end

    // Pointer, level and flag registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    // Storage array; contents are not reset, the pointers make stale data unreachable.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data;
    end

    // Standard read register: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            rd_data_q <= '0;
        else if (rd_accept) rd_data_q <= mem[rd_ptr_q[DEPTH_WIDTH-1:0]];
    end

`ifdef FIFO_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] rd_pipe_q;

    // Extra output stage for timing; follows the read register every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_pipe_q <= '0;
        else     rd_pipe_q <= rd_data_q;
    end

    assign rd_data = rd_pipe_q;
`else
    assign rd_data = rd_data_q;
`endif

    assign wr_full        = full_q;
    assign almost_full    = afull_q;
    assign rd_empty       = empty_q;
    assign almost_empty   = aempty_q;
    assign rd_water_level = level_q;

endmodule

// File: tb/tb_fifo_2048x8.sv
// Directed bench for fifo_2048x8: fill/drain, thresholds, simultaneous access, async reset.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Works with and without FIFO_OUTPUT_REG_EN; the data checks account for the read latency.
module tb_fifo_2048x8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  wr_data = '0;
    logic        wr_en = 1'b0;
    logic        wr_full;
    logic        almost_full;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_empty;
    logic [11:0] rd_water_level;
    logic        almost_empty;

    int total = 0;
    int bad   = 0;

    // Reference contents and read-port expectation.
    logic [7:0] mq[$];
    logic [7:0] m_rd  = '0;
    logic [7:0] m_out = '0;

    fifo_2048x8 dut (
        .clk            (clk),
        .rst            (rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .almost_full    (almost_full),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Value rd_data should show now, given the read latency of the build.
    function automatic logic [7:0] exp_data();
`ifdef FIFO_OUTPUT_REG_EN
        return m_out;
`else
        return m_rd;
`endif
    endfunction

    // One clock cycle with the given requests; updates the reference afterwards.
    task automatic cyc(input bit we, input logic [7:0] d, input bit re);
        bit wa;
        bit ra;
        wa = we && (mq.size() < 2048);
        ra = re && (mq.size() > 0);
        wr_en   = we;
        wr_data = d;
        rd_en   = re;
        @(posedge clk);
        #1;
        m_out = m_rd;
        if (ra) m_rd = mq.pop_front();
        if (wa) mq.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", rd_water_level, 0);
        chk("rst_empty", rd_empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", wr_full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_data", rd_data, 0);
        rst = 1'b0;

        // Fill with a down-counter for 2049 cycles; the last write must drop.
        for (int k = 0; k < 2049; k++) begin
            cyc(1'b1, 8'(255 - (k % 256)), 1'b0);
            if (k == 3)    chk("fill_ae_l4", almost_empty, 1);
            if (k == 4)    chk("fill_ae_l5", almost_empty, 0);
            if (k == 1018) chk("fill_af_l1019", almost_full, 0);
            if (k == 1019) chk("fill_af_l1020", almost_full, 1);
            if (k == 1019) chk("fill_lvl_1020", rd_water_level, 1020);
            if (k == 2046) chk("fill_full_l2047", wr_full, 0);
            if (k == 2047) chk("fill_full_l2048", wr_full, 1);
        end
        chk("fill_level", rd_water_level, 2048);
        chk("fill_full", wr_full, 1);
        chk("fill_empty", rd_empty, 0);

        // Drain for 2049 cycles: 255..0 eight times, then an ignored read.
        for (int j = 0; j < 2049; j++) begin
            cyc(1'b0, 8'h00, 1'b1);
`ifdef FIFO_OUTPUT_REG_EN
            if (j >= 1) chk("drain_data", rd_data, 255 - ((j - 1) % 256));
`else
            chk("drain_data", rd_data, (j < 2048) ? 255 - (j % 256) : 0);
`endif
            if (j == 2047) chk("drain_empty_last", rd_empty, 1);
        end
        idle();
        chk("drain_hold", rd_data, 0);
        chk("drain_level", rd_water_level, 0);
        chk("drain_empty", rd_empty, 1);
        chk("drain_afull", almost_full, 0);

        // Empty-side threshold.
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            if (i == 4) chk("ae_l4", almost_empty, 1);
        end
        chk("ae_l5", almost_empty, 0);
        chk("ae_level5", rd_water_level, 5);
        cyc(1'b0, 8'h00, 1'b1);
        chk("ae_back_l4", almost_empty, 1);
        chk("ae_level4", rd_water_level, 4);
        idle();
        chk("ae_rd_first", rd_data, 1);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        idle();
        chk("rd_on_empty_level", rd_water_level, 0);
        chk("rd_on_empty_flag", rd_empty, 1);
        chk("rd_on_empty_hold", rd_data, 5);

        // Simultaneous read/write on empty: only the write happens.
        cyc(1'b1, 8'hA5, 1'b1);
        chk("sim_empty_level", rd_water_level, 1);
        chk("sim_empty_flag", rd_empty, 0);
        chk("sim_empty_data", rd_data, 5);

        // Simultaneous read/write at level 10 for 20 cycles.
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        chk("sim10_start", rd_water_level, 10);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'(8'h40 + i), 1'b1);
            chk("sim10_level", rd_water_level, 10);
            chk("sim10_data", rd_data, exp_data());
        end
        idle();
        chk("sim10_last", rd_data, 8'h49);

        // Simultaneous read/write when full: only the read happens.
        for (int i = 0; i < 2038; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("sfull_level", rd_water_level, 2048);
        chk("sfull_flag", wr_full, 1);
        cyc(1'b1, 8'hEE, 1'b1);
        chk("sfull_level_after", rd_water_level, 2047);
        chk("sfull_flag_after", wr_full, 0);
        idle();
        chk("sfull_data", rd_data, 8'h4A);

        // Bring the level to 1500, then reset asynchronously mid-cycle.
        for (int i = 0; i < 547; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("pre_rst_level", rd_water_level, 1500);
        chk("pre_rst_afull", almost_full, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level", rd_water_level, 0);
        chk("arst_empty", rd_empty, 1);
        chk("arst_aempty", almost_empty, 1);
        chk("arst_full", wr_full, 0);
        chk("arst_afull", almost_full, 0);
        chk("arst_data", rd_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_rd  = '0;
        m_out = '0;

        // Traffic after reset starts from empty.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h31 + i), 1'b0);
        chk("post_rst_level", rd_water_level, 3);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("post_rst_data", rd_data, exp_data());
        end
        idle();
        chk("post_rst_last", rd_data, 8'h33);
        chk("post_rst_empty", rd_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
